store_forward_queue: RTL and testbench
======================================

Name: store_forward_queue

Overview:
- Parametrised store queue with store-to-load forwarding; generalises the word-granular LSQ entry format to multi-word blocks with per-byte write enables.
- Sits in the load-store unit between the store pipeline (address/data update), commit logic, and the D-cache write port.
- Serves registered forwarding lookups from the load pipeline.

Parameters:
ENTRY_NUM, 16, number of store entries (power of two, >=2)
BLOCK_WIDTH, 64, data bits per entry (multiple of 32)
ADDR_WIDTH, 32, physical byte-address width
Derived: IDX_W=$clog2(ENTRY_NUM), BYTES=BLOCK_WIDTH/8, OFS_W=$clog2(BYTES), BADDR_W=ADDR_WIDTH-OFS_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
allocReq  in  1  allocate one entry at tail
allocPtr  out  IDX_W+1  current tail pointer (wrap bit in MSB); allocated index when allocReq accepted
full  out  1  ENTRY_NUM entries occupied
empty  out  1  no entries occupied
updateValid  in  1  write address/data to an allocated entry
updateIdx  in  IDX_W  entry index
updateBlockAddr  in  BADDR_W  block address
updateByteWE  in  BYTES  byte enables
updateData  in  BLOCK_WIDTH  store data, byte-lane aligned
commitReq  in  1  head-side entry becomes committed (non-speculative)
recoverValid  in  1  squash speculative stores
recoverTail  in  IDX_W+1  new tail pointer after squash
retireValid  out  1  oldest committed entry offered to cache
retireReady  in  1  cache accepts offered entry
retireBlockAddr  out  BADDR_W  offered block address
retireByteWE  out  BYTES  offered byte enables
retireData  out  BLOCK_WIDTH  offered data
fwdReq  in  1  load lookup request
fwdBlockAddr  in  BADDR_W  load block address
fwdByteRE  in  BYTES  load byte read enables
fwdOlderTail  in  IDX_W+1  tail pointer at load dispatch (stores strictly older are [head, fwdOlderTail))
fwdValid  out  1  lookup result valid (1 cycle after fwdReq)
fwdHit  out  1  all requested bytes supplied by stores
fwdPartial  out  1  some but not all requested bytes covered
fwdConflict  out  1  an older store in range has unknown address
fwdData  out  BLOCK_WIDTH  forwarded bytes; uncovered lanes zero

Behaviour:
- Pointers: head, commitPtr, tail, each IDX_W+1 bits with wrap bit. count=tail-head (mod 2^(IDX_W+1)). full=(count==ENTRY_NUM), empty=(count==0). Invariant: head<=commitPtr<=tail.
- Reset: head=commitPtr=tail=0; all entry addrValid=0; all outputs 0 except empty=1; fwdValid=0. Reset mid-retire drops the offered entry; reset has priority over every other input.
- Alloc: allocReq && !full -> entry[tail] addrValid=0, tail+=1 next cycle. allocReq while full is ignored; full is evaluated on the pre-cycle state, so a same-cycle retire does not admit the alloc.
- Update: updateValid -> entry[updateIdx] gets addr, byteWE, data, addrValid=1 next cycle. An update to an unallocated index is illegal (assertion).
- Commit: commitReq && commitPtr!=tail -> commitPtr+=1. Otherwise ignored.
- Retire: retireValid=(head!=commitPtr) && entry[head].addrValid, driven combinationally from entry[head]. On retireValid && retireReady, head+=1 and entry addrValid is cleared. Fields are held stable while retireValid && !retireReady.
- Recover: recoverValid -> tail=recoverTail. Requires commitPtr<=recoverTail<=tail (assertion). Same-cycle allocReq is ignored. Commit and retire proceed normally in the same cycle.
- Forwarding, one-cycle registered:
  - On fwdReq, scan entries i in [head, fwdOlderTail) using state sampled that cycle.
  - Entry i matches if addrValid && blockAddr==fwdBlockAddr.
  - For each byte b with fwdByteRE[b], the youngest matching entry with byteWE[b] supplies the byte.
  - conflict = any entry in range with addrValid=0.
  - covered = OR of supplied lanes. hit = !conflict && covered==fwdByteRE && fwdByteRE!=0. partial = !conflict && covered!=0 && covered!=fwdByteRE.
  - Results are registered; fwdValid=1 the next cycle only. Without fwdReq, fwdValid=0 and the other fwd outputs are 0.
  - An empty range (fwdOlderTail==head) gives hit=partial=conflict=0.
  - A same-cycle update to an in-range entry is not visible to the lookup.
- Wrap-around: index=ptr[IDX_W-1:0]. Age order is by distance from head, so ranges crossing index ENTRY_NUM-1 -> 0 must work.

Test Plan:
- Reset then allocate 16 with allocReq -> full=1 after 16th, allocPtr=5'h10. 17th allocReq ignored; allocPtr stays 5'h10.
- Update idx0 addr=0x100 WE=8'h0F data=0x...44332211, commit, retireReady=0 for 3 cycles -> retireValid held with stable fields. retireReady=1 -> head=1, empty=1.
- Forwarding merge:
  - Stores at idx1 (addr 0x20, WE 8'h03, data 0xAABB) and idx2 (addr 0x20, WE 8'h01, data 0xCC).
  - Load fwdByteRE=8'h03, fwdOlderTail=3 -> next cycle fwdHit=1, fwdData[15:0]=0xAACC.
  - Same load with fwdByteRE=8'h0F -> fwdPartial=1.
- Allocated-but-unupdated older entry in range -> fwdConflict=1, fwdHit=0. Same entry outside range (fwdOlderTail excludes it) -> no conflict.
- Recover: tail=8, commitPtr=3, recoverTail=5 with allocReq same cycle -> allocPtr=5, no allocation. Later lookups never match idx5-7.
- Wrap:
  - Advance head to 14; allocate 4 (idx14,15,0,1), update all to the same address with increasing data.
  - Lookup with fwdOlderTail=head+4 -> data of idx1 forwarded.
  - Assert rst mid-sequence -> empty=1, retireValid=0, fwdValid=0 next cycle.

Source files
------------

// File: rtl/store_forward_queue.sv
// Store queue with in-order commit/retire to the D-cache and registered
// store-to-load forwarding over multi-word blocks with per-byte enables.
module store_forward_queue #(
  parameter int ENTRY_NUM   = 16,
  parameter int BLOCK_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32,
  localparam int IDX_W      = $clog2(ENTRY_NUM),
  localparam int BYTES      = BLOCK_WIDTH / 8,
  localparam int OFS_W      = $clog2(BYTES),
  localparam int BADDR_W    = ADDR_WIDTH - OFS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   allocReq,
  output logic [IDX_W:0]         allocPtr,
  output logic                   full,
  output logic                   empty,
  input  logic                   updateValid,
  input  logic [IDX_W-1:0]       updateIdx,
  input  logic [BADDR_W-1:0]     updateBlockAddr,
  input  logic [BYTES-1:0]       updateByteWE,
  input  logic [BLOCK_WIDTH-1:0] updateData,
  input  logic                   commitReq,
  input  logic                   recoverValid,
  input  logic [IDX_W:0]         recoverTail,
  output logic                   retireValid,
  input  logic                   retireReady,
  output logic [BADDR_W-1:0]     retireBlockAddr,
  output logic [BYTES-1:0]       retireByteWE,
  output logic [BLOCK_WIDTH-1:0] retireData,
  input  logic                   fwdReq,
  input  logic [BADDR_W-1:0]     fwdBlockAddr,
  input  logic [BYTES-1:0]       fwdByteRE,
  input  logic [IDX_W:0]         fwdOlderTail,
  output logic                   fwdValid,
  output logic                   fwdHit,
  output logic                   fwdPartial,
  output logic                   fwdConflict,
  output logic [BLOCK_WIDTH-1:0] fwdData
);

  logic [IDX_W:0]         r_head;
  logic [IDX_W:0]         r_commit;
  logic [IDX_W:0]         r_tail;
  logic [ENTRY_NUM-1:0]   r_addr_valid;
  logic [BADDR_W-1:0]     r_block_addr [ENTRY_NUM];
  logic [BYTES-1:0]       r_byte_we    [ENTRY_NUM];
  logic [BLOCK_WIDTH-1:0] r_data       [ENTRY_NUM];

  logic                   r_fwd_valid;
  logic                   r_fwd_hit;
  logic                   r_fwd_partial;
  logic                   r_fwd_conflict;
  logic [BLOCK_WIDTH-1:0] r_fwd_data;

  logic [IDX_W:0]   w_count;
  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W:0]   w_tail_eff;
  logic             w_alloc;
  logic             w_commit;
  logic             w_retire_valid;
  logic             w_retire;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == (IDX_W+1)'(ENTRY_NUM));
  assign w_empty    = (w_count == '0);
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];

  // A squash wins over allocation; commit is bounded by the post-squash tail
  // so commitPtr can never overtake tail.
  assign w_alloc        = allocReq && !w_full && !recoverValid;
  assign w_tail_eff     = recoverValid ? recoverTail : r_tail;
  assign w_commit       = commitReq && (r_commit != w_tail_eff);
  assign w_retire_valid = (r_head != r_commit) && r_addr_valid[w_head_idx];
  assign w_retire       = w_retire_valid && retireReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_commit     <= '0;
      r_tail       <= '0;
      r_addr_valid <= '0;
    end else begin
      if (recoverValid)  r_tail <= recoverTail;
      else if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_commit)      r_commit <= r_commit + 1'b1;
      if (w_retire) begin
        r_head                   <= r_head + 1'b1;
        r_addr_valid[w_head_idx] <= 1'b0;
      end
      if (updateValid)   r_addr_valid[updateIdx]  <= 1'b1;
      if (w_alloc)       r_addr_valid[w_tail_idx] <= 1'b0;
    end
  end

  // NOTE: payload arrays carry no reset; addrValid gates every use, so reset
  // state is fully defined while the storage stays plain RAM.
  always_ff @(posedge clk) begin
    if (updateValid) begin
      r_block_addr[updateIdx] <= updateBlockAddr;
      r_byte_we[updateIdx]    <= updateByteWE;
      r_data[updateIdx]       <= updateData;
    end
  end

  assign retireValid     = w_retire_valid;
  assign retireBlockAddr = w_retire_valid ? r_block_addr[w_head_idx] : '0;
  assign retireByteWE    = w_retire_valid ? r_byte_we[w_head_idx]    : '0;
  assign retireData      = w_retire_valid ? r_data[w_head_idx]       : '0;

  logic [IDX_W:0]         w_fwd_len;
  logic [IDX_W-1:0]       w_age_idx [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   w_in_range;
  logic                   w_conflict;
  logic [BYTES-1:0]       w_covered;
  logic [BLOCK_WIDTH-1:0] w_fwd_data;

  assign w_fwd_len = fwdOlderTail - r_head;

  // Slot k is the k-th oldest entry counted from head, so age order survives wrap.
  for (genvar k = 0; k < ENTRY_NUM; k++) begin : g_age
    assign w_age_idx[k]  = w_head_idx + IDX_W'(k);
    assign w_in_range[k] = ((IDX_W+1)'(k) < w_fwd_len);
  end

  // NOTE: defaults first keep this block latch-free, and blocking overwrites
  // while walking oldest to youngest leave the youngest supplier in each lane.
  always_comb begin
    w_conflict = 1'b0;
    w_covered  = '0;
    w_fwd_data = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      if (w_in_range[k]) begin
        if (!r_addr_valid[w_age_idx[k]]) begin
          w_conflict = 1'b1;
        end else if (r_block_addr[w_age_idx[k]] == fwdBlockAddr) begin
          for (int b = 0; b < BYTES; b++) begin
            if (fwdByteRE[b] && r_byte_we[w_age_idx[k]][b]) begin
              w_covered[b]          = 1'b1;
              w_fwd_data[8*b +: 8]  = r_data[w_age_idx[k]][8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !fwdReq) begin
      r_fwd_valid    <= 1'b0;
      r_fwd_hit      <= 1'b0;
      r_fwd_partial  <= 1'b0;
      r_fwd_conflict <= 1'b0;
      r_fwd_data     <= '0;
    end else begin
      r_fwd_valid    <= 1'b1;
      r_fwd_hit      <= !w_conflict && (w_covered == fwdByteRE) && (fwdByteRE != '0);
      r_fwd_partial  <= !w_conflict && (w_covered != '0) && (w_covered != fwdByteRE);
      r_fwd_conflict <= w_conflict;
      r_fwd_data     <= w_fwd_data;
    end
  end

  assign allocPtr    = r_tail;
  assign full        = w_full;
  assign empty       = w_empty;
  assign fwdValid    = r_fwd_valid;
  assign fwdHit      = r_fwd_hit;
  assign fwdPartial  = r_fwd_partial;
  assign fwdConflict = r_fwd_conflict;
  assign fwdData     = r_fwd_data;

  logic [IDX_W-1:0] w_upd_dist;
  logic             w_upd_alloc;
  logic [IDX_W:0]   w_rec_dist;
  logic [IDX_W:0]   w_commit_dist;
  logic             w_rec_ok;

  assign w_upd_dist    = updateIdx - w_head_idx;
  assign w_upd_alloc   = w_full || ({1'b0, w_upd_dist} < w_count);
  assign w_rec_dist    = recoverTail - r_head;
  assign w_commit_dist = r_commit - r_head;
  assign w_rec_ok      = (w_rec_dist >= w_commit_dist) && (w_rec_dist <= w_count);

  a_update_allocated: assert property (@(posedge clk) disable iff (rst)
    updateValid |-> w_upd_alloc);
  a_recover_in_range: assert property (@(posedge clk) disable iff (rst)
    recoverValid |-> w_rec_ok);

endmodule

// File: tb/tb_store_forward_queue.sv
// Directed bench for store_forward_queue: alloc/full, retire hold, forwarding
// merge, conflict, recover and wrap-around with mid-sequence reset.
module tb_store_forward_queue;

  localparam int BAW = 29;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          allocReq;
  logic [4:0]    allocPtr;
  logic          full;
  logic          empty;
  logic          updateValid;
  logic [3:0]    updateIdx;
  logic [BAW-1:0] updateBlockAddr;
  logic [7:0]    updateByteWE;
  logic [63:0]   updateData;
  logic          commitReq;
  logic          recoverValid;
  logic [4:0]    recoverTail;
  logic          retireValid;
  logic          retireReady;
  logic [BAW-1:0] retireBlockAddr;
  logic [7:0]    retireByteWE;
  logic [63:0]   retireData;
  logic          fwdReq;
  logic [BAW-1:0] fwdBlockAddr;
  logic [7:0]    fwdByteRE;
  logic [4:0]    fwdOlderTail;
  logic          fwdValid;
  logic          fwdHit;
  logic          fwdPartial;
  logic          fwdConflict;
  logic [63:0]   fwdData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_forward_queue dut (
    .clk(clk), .rst(rst),
    .allocReq(allocReq), .allocPtr(allocPtr), .full(full), .empty(empty),
    .updateValid(updateValid), .updateIdx(updateIdx),
    .updateBlockAddr(updateBlockAddr), .updateByteWE(updateByteWE),
    .updateData(updateData),
    .commitReq(commitReq),
    .recoverValid(recoverValid), .recoverTail(recoverTail),
    .retireValid(retireValid), .retireReady(retireReady),
    .retireBlockAddr(retireBlockAddr), .retireByteWE(retireByteWE),
    .retireData(retireData),
    .fwdReq(fwdReq), .fwdBlockAddr(fwdBlockAddr), .fwdByteRE(fwdByteRE),
    .fwdOlderTail(fwdOlderTail),
    .fwdValid(fwdValid), .fwdHit(fwdHit), .fwdPartial(fwdPartial),
    .fwdConflict(fwdConflict), .fwdData(fwdData)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    allocReq = 1'b0; updateValid = 1'b0; updateIdx = '0; updateBlockAddr = '0;
    updateByteWE = '0; updateData = '0; commitReq = 1'b0; recoverValid = 1'b0;
    recoverTail = '0; retireReady = 1'b0; fwdReq = 1'b0; fwdBlockAddr = '0;
    fwdByteRE = '0; fwdOlderTail = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input int n);
    allocReq = 1'b1;
    repeat (n) tick();
    allocReq = 1'b0;
  endtask

  task automatic do_update(input logic [3:0] idx, input logic [BAW-1:0] addr,
                           input logic [7:0] we, input logic [63:0] data);
    updateValid = 1'b1; updateIdx = idx; updateBlockAddr = addr;
    updateByteWE = we; updateData = data;
    tick();
    updateValid = 1'b0;
  endtask

  task automatic do_commit(input int n);
    commitReq = 1'b1;
    repeat (n) tick();
    commitReq = 1'b0;
  endtask

  task automatic do_fwd(input logic [BAW-1:0] addr, input logic [7:0] re,
                        input logic [4:0] older);
    fwdReq = 1'b1; fwdBlockAddr = addr; fwdByteRE = re; fwdOlderTail = older;
    tick();
    fwdReq = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    checks++;
    if ({empty, full, retireValid, fwdValid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b exp %b", {empty, full, retireValid, fwdValid}, 4'b1000);
    end
    checks++;
    if (allocPtr !== 5'h00) begin
      errors++; $display("FAIL reset_alloc_ptr got %h exp %h", allocPtr, 5'h00);
    end
    checks++;
    if ({retireData, fwdData} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {retireData, fwdData});
    end
  endtask

  task automatic test_alloc_full();
    allocReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin
          errors++; $display("FAIL full_at_15 got %b exp %b", full, 1'b0);
        end
      end
    end
    checks++;
    if ({full, empty, allocPtr} !== {1'b1, 1'b0, 5'h10}) begin
      errors++;
      $display("FAIL full_at_16 got full=%b empty=%b ptr=%h exp full=1 empty=0 ptr=10", full, empty, allocPtr);
    end
    tick();
    allocReq = 1'b0;
    checks++;
    if ({full, allocPtr} !== {1'b1, 5'h10}) begin
      errors++; $display("FAIL alloc_when_full got full=%b ptr=%h exp full=1 ptr=10", full, allocPtr);
    end
  endtask

  task automatic test_retire_hold();
    do_reset();
    do_alloc(1);
    do_update(4'd0, 29'h100, 8'h0F, 64'h8877665544332211);
    checks++;
    if (retireValid !== 1'b0) begin
      errors++; $display("FAIL retire_before_commit got %b exp %b", retireValid, 1'b0);
    end
    do_commit(1);
    retireReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({retireValid, retireBlockAddr, retireByteWE, retireData} !==
          {1'b1, 29'h100, 8'h0F, 64'h8877665544332211}) begin
        errors++;
        $display("FAIL retire_hold_%0d got v=%b a=%h we=%h d=%h exp v=1 a=100 we=0f d=8877665544332211",
                 c, retireValid, retireBlockAddr, retireByteWE, retireData);
      end
      tick();
    end
    retireReady = 1'b1;
    tick();
    retireReady = 1'b0;
    checks++;
    if ({empty, retireValid, allocPtr} !== {1'b1, 1'b0, 5'h01}) begin
      errors++;
      $display("FAIL retire_accept got empty=%b v=%b ptr=%h exp empty=1 v=0 ptr=01", empty, retireValid, allocPtr);
    end
  endtask

  task automatic test_fwd_merge();
    do_alloc(2);
    do_update(4'd1, 29'h20, 8'h03, 64'hAABB);
    do_update(4'd2, 29'h20, 8'h01, 64'hCC);
    do_fwd(29'h20, 8'h03, 5'd3);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'hAACC}) begin
      errors++;
      $display("FAIL fwd_merge_hit got flags=%b data=%h exp flags=1100 data=aacc",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    tick();
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b0000, 64'h0}) begin
      errors++;
      $display("FAIL fwd_idle got flags=%b data=%h exp flags=0000 data=0",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h20, 8'h0F, 5'd3);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1010, 64'hAACC}) begin
      errors++;
      $display("FAIL fwd_partial got flags=%b data=%h exp flags=1010 data=aacc",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h20, 8'h03, 5'd2);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'hAABB}) begin
      errors++;
      $display("FAIL fwd_older_only got flags=%b data=%h exp flags=1100 data=aabb",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h21, 8'h03, 5'd3);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1000, 64'h0}) begin
      errors++;
      $display("FAIL fwd_addr_miss got flags=%b data=%h exp flags=1000 data=0",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h20, 8'h03, 5'd1);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1000, 64'h0}) begin
      errors++;
      $display("FAIL fwd_empty_range got flags=%b data=%h exp flags=1000 data=0",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
  endtask

  task automatic test_conflict();
    do_alloc(1);
    fwdReq = 1'b1; fwdBlockAddr = 29'h20; fwdByteRE = 8'h03; fwdOlderTail = 5'd4;
    updateValid = 1'b1; updateIdx = 4'd3; updateBlockAddr = 29'h30;
    updateByteWE = 8'hFF; updateData = 64'h3333;
    tick();
    fwdReq = 1'b0; updateValid = 1'b0;
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict} !== 4'b1001) begin
      errors++;
      $display("FAIL fwd_conflict got flags=%b exp flags=1001", {fwdValid, fwdHit, fwdPartial, fwdConflict});
    end
    do_fwd(29'h20, 8'h03, 5'd3);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'hAACC}) begin
      errors++;
      $display("FAIL fwd_conflict_excluded got flags=%b data=%h exp flags=1100 data=aacc",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h20, 8'h03, 5'd4);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'hAACC}) begin
      errors++;
      $display("FAIL fwd_after_update got flags=%b data=%h exp flags=1100 data=aacc",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
  endtask

  task automatic test_recover();
    do_alloc(4);
    for (int i = 4; i < 8; i++)
      do_update(4'(i), 29'h40, 8'hFF, {32'hD0D0D0D0, 32'(i)});
    do_commit(2);
    checks++;
    if (allocPtr !== 5'd8) begin
      errors++; $display("FAIL recover_pre_tail got %h exp %h", allocPtr, 5'd8);
    end
    recoverValid = 1'b1; recoverTail = 5'd5; allocReq = 1'b1;
    tick();
    recoverValid = 1'b0; allocReq = 1'b0;
    checks++;
    if ({full, allocPtr} !== {1'b0, 5'd5}) begin
      errors++; $display("FAIL recover_tail got full=%b ptr=%h exp full=0 ptr=05", full, allocPtr);
    end
    checks++;
    if ({retireValid, retireBlockAddr, retireData} !== {1'b1, 29'h20, 64'hAABB}) begin
      errors++;
      $display("FAIL recover_retire_head got v=%b a=%h d=%h exp v=1 a=20 d=aabb",
               retireValid, retireBlockAddr, retireData);
    end
    do_alloc(1);
    do_fwd(29'h40, 8'hFF, 5'd6);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict} !== 4'b1001) begin
      errors++;
      $display("FAIL recover_realloc_conflict got flags=%b exp flags=1001", {fwdValid, fwdHit, fwdPartial, fwdConflict});
    end
    do_update(4'd5, 29'h60, 8'hFF, 64'h6666);
    do_fwd(29'h40, 8'hFF, 5'd6);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'hD0D0D0D000000004}) begin
      errors++;
      $display("FAIL recover_no_squashed_match got flags=%b data=%h exp flags=1100 data=d0d0d0d000000004",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      do_alloc(1);
      do_update(4'(i), 29'h7, 8'hFF, 64'(i));
      do_commit(1);
      retireReady = 1'b1;
      tick();
      retireReady = 1'b0;
    end
    checks++;
    if ({empty, allocPtr} !== {1'b1, 5'd14}) begin
      errors++; $display("FAIL wrap_head14 got empty=%b ptr=%h exp empty=1 ptr=0e", empty, allocPtr);
    end
    do_alloc(4);
    checks++;
    if (allocPtr !== 5'h12) begin
      errors++; $display("FAIL wrap_alloc_ptr got %h exp %h", allocPtr, 5'h12);
    end
    do_update(4'd14, 29'h80, 8'hFF, 64'd1);
    do_update(4'd15, 29'h80, 8'hFF, 64'd2);
    do_update(4'd0,  29'h80, 8'hFF, 64'd3);
    do_update(4'd1,  29'h80, 8'hFF, 64'd4);
    do_fwd(29'h80, 8'hFF, 5'h12);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'd4}) begin
      errors++;
      $display("FAIL wrap_youngest got flags=%b data=%h exp flags=1100 data=4",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h80, 8'hFF, 5'h10);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1100, 64'd2}) begin
      errors++;
      $display("FAIL wrap_before_zero got flags=%b data=%h exp flags=1100 data=2",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_fwd(29'h7, 8'hFF, 5'h12);
    checks++;
    if ({fwdValid, fwdHit, fwdPartial, fwdConflict, fwdData} !== {4'b1000, 64'h0}) begin
      errors++;
      $display("FAIL wrap_retired_no_match got flags=%b data=%h exp flags=1000 data=0",
               {fwdValid, fwdHit, fwdPartial, fwdConflict}, fwdData);
    end
    do_commit(1);
    checks++;
    if ({retireValid, retireData} !== {1'b1, 64'd1}) begin
      errors++; $display("FAIL wrap_retire_offer got v=%b d=%h exp v=1 d=1", retireValid, retireData);
    end
    rst = 1'b1; retireReady = 1'b1;
    fwdReq = 1'b1; fwdBlockAddr = 29'h80; fwdByteRE = 8'hFF; fwdOlderTail = 5'h12;
    tick();
    rst = 1'b0; retireReady = 1'b0; fwdReq = 1'b0;
    checks++;
    if ({empty, retireValid, fwdValid, allocPtr} !== {3'b100, 5'h00}) begin
      errors++;
      $display("FAIL mid_reset got empty=%b rv=%b fv=%b ptr=%h exp empty=1 rv=0 fv=0 ptr=00",
               empty, retireValid, fwdValid, allocPtr);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alloc_full();
    test_retire_hold();
    test_fwd_merge();
    test_conflict();
    test_recover();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
